hw_int_ctrl: RTL and testbench

Programmable interrupt controller between the six external device interrupt lines and the CPU's `HWInt[7:2]` inputs. It sits on the bridge as a memory-mapped slave at 0x7F40–0x7F4F. The block synchronizes each device line and latches it as level- or edge-triggered. It masks the latched requests, tracks nested in-service sources by fixed priority, and lets the exception handler claim and complete interrupts through register accesses.

---
 rtl/hw_int_ctrl.sv | 135 +++++++++++++
 tb/tb_hw_int_ctrl.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/hw_int_ctrl.sv
// Memory-mapped interrupt controller: synchronizes six device lines, latches them
// as level/edge requests, masks them and nests in-service sources by fixed priority.
module hw_int_ctrl #(
  parameter int unsigned NSRC = 6
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] dev_irq,
  input  logic            sel,
  input  logic [1:0]      addr,
  input  logic            we,
  input  logic            re,
  input  logic [31:0]     wdata,
  output logic [31:0]     rdata,
  output logic [NSRC-1:0] HWInt
);

  typedef enum logic [1:0] {
    REG_ENABLE  = 2'd0,
    REG_PENDING = 2'd1,
    REG_MODE    = 2'd2,
    REG_CLAIM   = 2'd3
  } reg_e;

  logic [NSRC-1:0] s1_q, s2_q, s3_q;
  logic [NSRC-1:0] enable_q, enable_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] pending_q, pending_d;
  logic [NSRC-1:0] in_service_q, in_service_d;
  logic [NSRC-1:0] hwint_q;

  logic [NSRC-1:0] eligible;
  logic [2:0]      cur_idx;
  logic [2:0]      elig_idx;
  logic            any_elig;
  logic            cur_found;
  logic            wr_hit, rd_hit;
  logic            do_claim, do_complete, do_w1c;
  logic [31:0]     claim_data;

  always_comb begin
    cur_idx   = 3'd6;
    cur_found = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (!cur_found && in_service_q[i]) begin
        cur_idx   = 3'(i);
        cur_found = 1'b1;
      end
    end

    eligible = '0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      eligible[i] = pending_q[i] & enable_q[i] & (i < 32'(cur_idx));
    end

    elig_idx = '0;
    any_elig = 1'b0;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (!any_elig && eligible[i]) begin
        elig_idx = 3'(i);
        any_elig = 1'b1;
      end
    end

    claim_data = any_elig ? {1'b1, 28'b0, elig_idx} : '0;
  end

  always_comb begin
    rdata = '0;
    case (addr)
      REG_ENABLE:  rdata[NSRC-1:0] = enable_q;
      REG_PENDING: rdata[NSRC-1:0] = pending_q;
      REG_MODE:    rdata[NSRC-1:0] = mode_q;
      REG_CLAIM:   rdata           = claim_data;
      default:     rdata           = '0;
    endcase
  end

  // A write in the same cycle as a read suppresses the read's claim side effect.
  always_comb begin
    wr_hit      = sel & we;
    rd_hit      = sel & re & ~we;
    do_claim    = rd_hit & (addr == REG_CLAIM) & any_elig;
    do_complete = wr_hit & (addr == REG_CLAIM);
    do_w1c      = wr_hit & (addr == REG_PENDING);

    enable_d = enable_q;
    mode_d   = mode_q;
    if (wr_hit && addr == REG_ENABLE) enable_d = wdata[NSRC-1:0];
    if (wr_hit && addr == REG_MODE)   mode_d   = wdata[NSRC-1:0];

    in_service_d = in_service_q;
    pending_d    = pending_q;
    for (int unsigned i = 0; i < NSRC; i++) begin
      if (do_claim && elig_idx == 3'(i))
        in_service_d[i] = 1'b1;
      if (do_complete && wdata[2:0] == 3'(i))
        in_service_d[i] = 1'b0;

      // Edge mode: a new edge on the same cycle as a clear keeps the bit set.
      if (mode_q[i]) begin
        pending_d[i] = (s2_q[i] & ~s3_q[i]) |
                       (pending_q[i] & ~((do_w1c & wdata[i]) |
                                         (do_claim && elig_idx == 3'(i))));
      end else begin
        pending_d[i] = s2_q[i];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q         <= '0;
      s2_q         <= '0;
      s3_q         <= '0;
      enable_q     <= '0;
      mode_q       <= '0;
      pending_q    <= '0;
      in_service_q <= '0;
      hwint_q      <= '0;
    end else begin
      s1_q         <= dev_irq;
      s2_q         <= s1_q;
      s3_q         <= s2_q;
      enable_q     <= enable_d;
      mode_q       <= mode_d;
      pending_q    <= pending_d;
      in_service_q <= in_service_d;
      hwint_q      <= eligible;
    end
  end

  assign HWInt = hwint_q;

endmodule

// File: tb/tb_hw_int_ctrl.sv
// Directed bench for hw_int_ctrl; stimulus queues expectations that a negedge
// monitor pops and compares against rdata / HWInt.
module tb_hw_int_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  dev_irq;
  logic        sel, we, re;
  logic [1:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [5:0]  HWInt;

  hw_int_ctrl #(.NSRC(6)) dut (
    .clk     (clk),
    .reset   (reset),
    .dev_irq (dev_irq),
    .sel     (sel),
    .addr    (addr),
    .we      (we),
    .re      (re),
    .wdata   (wdata),
    .rdata   (rdata),
    .HWInt   (HWInt)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    bit          hw;
    logic [31:0] exp;
  } item_t;

  item_t q[$];
  int    total = 0;
  int    bad   = 0;

  always @(negedge clk) begin
    while (q.size() > 0) begin
      item_t       it;
      logic [31:0] act;
      it  = q.pop_front();
      act = it.hw ? {26'b0, HWInt} : rdata;
      total++;
      if (act !== it.exp) begin
        bad++;
        $display("FAIL %s: got %h expected %h", it.name, act, it.exp);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input string name, input bit hw, input logic [31:0] exp);
    item_t it;
    it.name = name;
    it.hw   = hw;
    it.exp  = exp;
    q.push_back(it);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    sel = 1'b1; we = 1'b1; re = 1'b0; addr = a; wdata = d;
    tick(1);
    sel = 1'b0; we = 1'b0; wdata = '0;
  endtask

  // Plain read (no claim side effect): re stays low.
  task automatic chk_rd(input logic [1:0] a, input logic [31:0] exp, input string name);
    sel = 1'b1; we = 1'b0; re = 1'b0; addr = a;
    push(name, 1'b0, exp);
    tick(1);
    sel = 1'b0;
  endtask

  task automatic claim(input logic [31:0] exp, input string name);
    sel = 1'b1; we = 1'b0; re = 1'b1; addr = 2'd3;
    push(name, 1'b0, exp);
    tick(1);
    sel = 1'b0; re = 1'b0;
  endtask

  task automatic chk_hw(input logic [5:0] exp, input string name);
    push(name, 1'b1, {26'b0, exp});
    tick(1);
  endtask

  // Level sources 3 and 5 claimed, then source 1 nests on top: in_service = 6'h0A.
  task automatic build_nest(input string tag);
    dev_irq = 6'h28;
    tick(5);
    chk_hw(6'h28, {tag, "_hw_3_5"});
    claim(32'h8000_0003, {tag, "_claim3"});
    tick(1);
    chk_hw(6'h00, {tag, "_hw_masked"});
    chk_rd(2'd3, 32'h0, {tag, "_peek_none"});
    dev_irq = 6'h2A;
    tick(5);
    chk_hw(6'h02, {tag, "_hw_1"});
    claim(32'h8000_0001, {tag, "_claim1"});
    tick(1);
    chk_hw(6'h00, {tag, "_hw_nested"});
  endtask

  initial begin
    reset = 1'b0; dev_irq = '0; sel = 1'b0; we = 1'b0; re = 1'b0;
    addr = '0; wdata = '0;
    tick(3);
    reset = 1'b1;

    chk_rd(2'd0, 32'h0, "rst_enable");
    chk_rd(2'd1, 32'h0, "rst_pending");
    chk_rd(2'd2, 32'h0, "rst_mode");
    chk_rd(2'd3, 32'h0, "rst_claim");
    chk_hw(6'h00, "rst_hwint");

    dev_irq = 6'h3F;
    tick(6);
    chk_hw(6'h00, "disabled_hw");
    chk_rd(2'd1, 32'h3F, "disabled_pending");
    chk_rd(2'd3, 32'h0, "disabled_claim");
    dev_irq = '0;
    tick(5);

    // Level latency: 4 rising edges each way.
    wr(2'd0, 32'h04);
    tick(2);
    dev_irq = 6'h04;
    tick(3);
    chk_hw(6'h00, "lvl_rise_e4_before");
    chk_hw(6'h04, "lvl_rise_e4_after");
    dev_irq = 6'h00;
    tick(3);
    chk_hw(6'h04, "lvl_fall_e4_before");
    chk_hw(6'h00, "lvl_fall_e4_after");

    // Edge mode on source 0.
    wr(2'd2, 32'h01);
    wr(2'd0, 32'h01);
    dev_irq = 6'h01;
    tick(1);
    dev_irq = 6'h00;
    tick(4);
    chk_rd(2'd1, 32'h01, "edge_latched");
    tick(3);
    chk_rd(2'd1, 32'h01, "edge_held");
    chk_hw(6'h01, "edge_hw");
    wr(2'd1, 32'h01);
    chk_rd(2'd1, 32'h00, "edge_w1c");
    dev_irq = 6'h01;
    tick(1);
    dev_irq = 6'h00;
    tick(1);
    wr(2'd1, 32'h01);
    chk_rd(2'd1, 32'h01, "edge_set_wins");
    wr(2'd1, 32'h01);
    chk_rd(2'd1, 32'h00, "edge_w1c2");

    // Claim / nesting on level sources.
    wr(2'd2, 32'h00);
    wr(2'd0, 32'h3F);
    build_nest("n1");

    wr(2'd3, 32'h07);
    wr(2'd3, 32'h05);
    tick(1);
    chk_hw(6'h00, "bad_complete_hw");
    chk_rd(2'd3, 32'h0, "bad_complete_claim");

    wr(2'd3, 32'h01);
    tick(1);
    chk_hw(6'h02, "complete1_hw");
    wr(2'd3, 32'h03);
    tick(1);
    chk_hw(6'h2A, "complete3_hw");
    chk_rd(2'd3, 32'h8000_0001, "complete3_claim");

    // Rebuild in_service = 6'h0A, add source 0 so HWInt is nonzero, then async reset.
    dev_irq = 6'h00;
    tick(5);
    build_nest("n2");
    dev_irq = 6'h2B;
    tick(5);
    chk_hw(6'h01, "pre_reset_hw");
    chk_rd(2'd1, 32'h2B, "pre_reset_pending");
    sel = 1'b1; addr = 2'd1; re = 1'b0; we = 1'b0;
    reset = 1'b0;
    push("async_rst_hw", 1'b1, 32'h0);
    push("async_rst_pending", 1'b0, 32'h0);
    tick(1);
    sel = 1'b0;
    chk_rd(2'd0, 32'h0, "async_rst_enable");
    chk_rd(2'd3, 32'h0, "async_rst_claim");
    dev_irq = '0;
    reset = 1'b1;
    tick(2);

    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d expected 0 queued items", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
